// File: rtl/tape_mem_pkg.sv
// tape_mem_pkg
//   Shared definitions for the tape SRAM responder and its verification model.
//   - tape_state_e : controller states (CLEAR, IDLE, RD, WR, WHOLD)
//   - NIB_PER_WORD : 4-bit tape cells packed into one 16-bit SRAM word
//   - nib_extract  : pull nibble <sel> out of a 16-bit word
//   - nib_insert   : replace nibble <sel> of a 16-bit word
package tape_mem_pkg;

  localparam int NIB_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_WHOLD
  } tape_state_e;

  // Nibble <sel> occupies bits [4*sel+3 : 4*sel].
  function automatic logic [3:0] nib_extract(input logic [15:0] word,
                                             input logic [1:0]  sel);
    return word[{sel, 2'b00} +: 4];
  endfunction

  function automatic logic [15:0] nib_insert(input logic [15:0] word,
                                             input logic [1:0]  sel,
                                             input logic [3:0]  nib);
    logic [15:0] w;
    w = word;
    w[{sel, 2'b00} +: 4] = nib;
    return w;
  endfunction

endpackage

// File: rtl/tape_sram_ctrl.sv
// tape_sram_ctrl
//   Serves the nibble-wide tape request interface of a Turing-machine core
//   from an external asynchronous 16-bit SRAM. Four tape cells share one
//   SRAM word; a nibble write is a read-modify-write of that word. After
//   reset the tape region can optionally be cleared to zero.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   m_ena                 : request valid, held until m_ack
//   m_write               : 1 = write, 0 = read
//   m_addr [ABITS]        : nibble address (word = m_addr[ABITS-1:2])
//   wr_data[4]            : nibble to write
//   rd_data[4]            : last read nibble (held until the next read)
//   m_busy                : controller occupied
//   m_ack                 : one-cycle accept pulse, always together with m_busy
//   sram_addr[SRAM_AW]    : SRAM word address, zero-extended
//   sram_dq_i/o[16]       : SRAM data from/to the pad buffer
//   sram_dq_oe            : pad drive enable (tristate lives in the board top)
//   sram_*_n              : active-low strobes; ub_n/lb_n follow ce_n
//
// Every output is a flop. The next-cycle value of each output is derived
// from the next state, so strobes line up exactly with the state they belong to.
module tape_sram_ctrl
  import tape_mem_pkg::*;
#(
  parameter int ABITS          = 16,
  parameter int SRAM_AW        = 18,
  parameter int WAIT           = 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m_ena,
  input  logic               m_write,
  input  logic [ABITS-1:0]   m_addr,
  input  logic [3:0]         wr_data,
  output logic [3:0]         rd_data,
  output logic               m_busy,
  output logic               m_ack,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [15:0]        sram_dq_i,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam int SELW = $clog2(NIB_PER_WORD);
  localparam int WW   = ABITS - SELW;
  localparam int CW   = $clog2(WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT - 1);
  localparam logic [CW-1:0] CNT_HOLD = CW'(WAIT);

  tape_state_e         state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                start_q, start_d;
  logic [WW-1:0]       word_q, word_d;
  logic                wr_q, wr_d;
  logic [SELW-1:0]     sel_q, sel_d;
  logic [3:0]          nib_q, nib_d;

  logic [3:0]          rd_data_q, rd_data_d;
  logic                busy_q, busy_d;
  logic                ack_q, ack_d;
  logic [SRAM_AW-1:0]  addr_q, addr_d;
  logic [15:0]         dq_o_q, dq_o_d;
  logic                dq_oe_q, dq_oe_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;
    word_d    = word_q;
    wr_d      = wr_q;
    sel_d     = sel_q;
    nib_d     = nib_q;
    rd_data_d = rd_data_q;
    dq_o_d    = dq_o_q;
    ack_d     = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        // The first cycle after reset only arms word 0; each word then gets
        // WAIT strobe cycles (cnt 0..WAIT-1) and one hold cycle (cnt == WAIT).
        if (start_q) begin
          cnt_d  = '0;
          word_d = '0;
        end else if (cnt_q == CNT_HOLD) begin
          cnt_d = '0;
          if (&word_q) state_d = ST_IDLE;
          else         word_d  = word_q + WW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_IDLE: begin
        if (m_ena) begin
          state_d = ST_RD;
          cnt_d   = '0;
          wr_d    = m_write;
          word_d  = m_addr[ABITS-1:SELW];
          sel_d   = m_addr[SELW-1:0];
          nib_d   = wr_data;
          ack_d   = 1'b1;
        end
      end
      ST_RD: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (wr_q) begin
            state_d = ST_WR;
            dq_o_d  = nib_insert(sram_dq_i, sel_q, nib_q);
          end else begin
            state_d   = ST_IDLE;
            rd_data_d = nib_extract(sram_dq_i, sel_q);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WR: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_WHOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WHOLD: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Registered outputs for the cycle the next state will occupy.
    busy_d  = 1'b1;
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    addr_d  = addr_q;
    case (state_d)
      ST_CLEAR: begin
        ce_n_d  = 1'b0;
        we_n_d  = (cnt_d == CNT_HOLD);
        dq_oe_d = 1'b1;
        dq_o_d  = '0;
        addr_d  = SRAM_AW'(word_d);
      end
      ST_IDLE: busy_d = 1'b0;
      ST_RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        addr_d = SRAM_AW'(word_d);
      end
      ST_WR: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        addr_d  = SRAM_AW'(word_d);
      end
      ST_WHOLD: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        addr_d  = SRAM_AW'(word_d);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      cnt_q     <= '0;
      start_q   <= 1'b1;
      word_q    <= '0;
      wr_q      <= 1'b0;
      sel_q     <= '0;
      nib_q     <= '0;
      rd_data_q <= '0;
      busy_q    <= 1'b1;
      ack_q     <= 1'b0;
      addr_q    <= '0;
      dq_o_q    <= '0;
      dq_oe_q   <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      word_q    <= word_d;
      wr_q      <= wr_d;
      sel_q     <= sel_d;
      nib_q     <= nib_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      addr_q    <= addr_d;
      dq_o_q    <= dq_o_d;
      dq_oe_q   <= dq_oe_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign m_busy     = busy_q;
  assign m_ack      = ack_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  // Both byte lanes are always used together.
  assign sram_ub_n  = ce_n_q;
  assign sram_lb_n  = ce_n_q;

endmodule

// File: tb/tb_tape_sram_ctrl.sv
// tb_tape_sram_ctrl
//   Two controller instances with behavioural async SRAM models:
//   A: ABITS=6,  WAIT=2, tape cleared after reset
//   B: ABITS=16, WAIT=2, no clear (full-width address corner)
//   Read expectations go into a scoreboard queue when a read is issued and are
//   popped when the controller drops m_busy.
module tb_tape_sram_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic        a_ena, a_write;
  logic [5:0]  a_maddr;
  logic [3:0]  a_wd, a_rd;
  logic        a_busy, a_ack;
  logic [17:0] a_saddr;
  logic [15:0] a_dq_i, a_dq_o;
  logic        a_dq_oe, a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n;

  tape_sram_ctrl #(.ABITS(6), .SRAM_AW(18), .WAIT(2), .CLEAR_ON_RESET(1'b1)) u_a (
    .clk(clk), .rst(rst),
    .m_ena(a_ena), .m_write(a_write), .m_addr(a_maddr), .wr_data(a_wd),
    .rd_data(a_rd), .m_busy(a_busy), .m_ack(a_ack),
    .sram_addr(a_saddr), .sram_dq_i(a_dq_i), .sram_dq_o(a_dq_o), .sram_dq_oe(a_dq_oe),
    .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n),
    .sram_ub_n(a_ub_n), .sram_lb_n(a_lb_n)
  );

  logic [15:0] mema [0:63];
  logic        pa_en;
  logic [5:0]  pa_a;
  logic [15:0] pa_d;
  assign a_dq_i = (!a_ce_n && !a_oe_n) ? mema[a_saddr[5:0]] : 16'hDEAD;
  always @(posedge clk) begin
    if (pa_en) mema[pa_a] <= pa_d;
    else if (!a_ce_n && !a_we_n && a_dq_oe) mema[a_saddr[5:0]] <= a_dq_o;
  end

  // ---------------- instance B ----------------
  logic        b_ena, b_write;
  logic [15:0] b_maddr;
  logic [3:0]  b_wd, b_rd;
  logic        b_busy, b_ack;
  logic [17:0] b_saddr;
  logic [15:0] b_dq_i, b_dq_o;
  logic        b_dq_oe, b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n;

  tape_sram_ctrl #(.ABITS(16), .SRAM_AW(18), .WAIT(2), .CLEAR_ON_RESET(1'b0)) u_b (
    .clk(clk), .rst(rst),
    .m_ena(b_ena), .m_write(b_write), .m_addr(b_maddr), .wr_data(b_wd),
    .rd_data(b_rd), .m_busy(b_busy), .m_ack(b_ack),
    .sram_addr(b_saddr), .sram_dq_i(b_dq_i), .sram_dq_o(b_dq_o), .sram_dq_oe(b_dq_oe),
    .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n),
    .sram_ub_n(b_ub_n), .sram_lb_n(b_lb_n)
  );

  logic [15:0] memb [0:16383];
  logic        pb_en;
  logic [13:0] pb_a;
  logic [15:0] pb_d;
  assign b_dq_i = (!b_ce_n && !b_oe_n) ? memb[b_saddr[13:0]] : 16'hDEAD;
  always @(posedge clk) begin
    if (pb_en) memb[pb_a] <= pb_d;
    else if (!b_ce_n && !b_we_n && b_dq_oe) memb[b_saddr[13:0]] <= b_dq_o;
  end

  // Strobe rule monitor: oe_n/we_n never both low, no drive while reading,
  // byte lanes track ce_n.
  int viol = 0;
  always @(negedge clk) begin
    if (!a_oe_n && !a_we_n) viol++;
    if (!a_oe_n && a_dq_oe) viol++;
    if (a_ub_n !== a_ce_n || a_lb_n !== a_ce_n) viol++;
    if (!b_oe_n && !b_we_n) viol++;
    if (!b_oe_n && b_dq_oe) viol++;
    if (b_ub_n !== b_ce_n || b_lb_n !== b_ce_n) viol++;
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [3:0] sbq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input string name, input logic [3:0] act);
    if (sbq.size() == 0) check({name, "_sb_underflow"}, 32'd1, 32'd0);
    else check(name, act, sbq.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prea(input logic [5:0] a, input logic [15:0] d);
    pa_en = 1'b1; pa_a = a; pa_d = d;
    tick();
    pa_en = 1'b0;
  endtask

  task automatic preb(input logic [13:0] a, input logic [15:0] d);
    pb_en = 1'b1; pb_a = a; pb_d = d;
    tick();
    pb_en = 1'b0;
  endtask

  // One request on A from an idle cycle (cycle 0). Reports first-ack cycle,
  // cycle where m_busy drops, and the number of acks seen.
  task automatic a_req(input logic wr, input logic [5:0] addr, input logic [3:0] wd,
                       input logic [3:0] exp_rd, output int ack_c, output int done_c,
                       output int nack);
    ack_c = -1; done_c = -1; nack = 0;
    if (!wr) sbq.push_back(exp_rd);
    a_ena = 1'b1; a_write = wr; a_maddr = addr; a_wd = wd;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (a_ack) begin
        nack++;
        if (ack_c < 0) ack_c = k;
        a_ena = 1'b0;
      end
      if (!a_busy && ack_c > 0 && k > ack_c) begin
        done_c = k;
        break;
      end
    end
    a_ena = 1'b0;
    if (done_c < 0) check("req_timeout", 32'd1, 32'd0);
    else if (!wr) sb_pop("req_rd_data", a_rd);
  endtask

  typedef struct {
    logic [5:0] addr;
    logic [3:0] exp;
  } rd_vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_vec_t tbl [8];
    int ack_c, done_c, nack, busy_cnt, acks, nz, idx, done, last_ack;
    logic prev_busy;

    // words 0 = 0xC3A5, 1 = 0x1E96, nibble i at bits [4i+3:4i]
    tbl[0] = '{6'h00, 4'h5}; tbl[1] = '{6'h01, 4'hA};
    tbl[2] = '{6'h02, 4'h3}; tbl[3] = '{6'h03, 4'hC};
    tbl[4] = '{6'h04, 4'h6}; tbl[5] = '{6'h05, 4'h9};
    tbl[6] = '{6'h06, 4'hE}; tbl[7] = '{6'h07, 4'h1};

    rst = 1'b1;
    a_ena = 0; a_write = 0; a_maddr = '0; a_wd = '0;
    b_ena = 0; b_write = 0; b_maddr = '0; b_wd = '0;
    pa_en = 0; pa_a = '0; pa_d = '0;
    pb_en = 0; pb_a = '0; pb_d = '0;
    tick();

    // ---- reset state; SRAM A filled with garbage, word 16 is outside the tape ----
    for (int i = 0; i < 64; i++) prea(6'(i), (i == 16) ? 16'hBEEF : 16'hFFFF);
    check("rst_busy", a_busy, 1);
    check("rst_ack", a_ack, 0);
    check("rst_rd_data", a_rd, 0);
    check("rst_strobes", {a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n}, 5'b11111);
    check("rst_dq_oe", a_dq_oe, 0);
    check("rst_sram_addr", a_saddr, 0);
    check("rst_dq_o", a_dq_o, 0);

    // ---- CLEAR: 16 words x 3 cycles, m_ena held but never acked ----
    a_ena = 1'b1; a_write = 1'b0; a_maddr = 6'h00;
    rst = 1'b0;
    busy_cnt = 0; acks = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (a_ack) acks++;
      if (!a_busy) break;
      busy_cnt++;
    end
    a_ena = 1'b0;
    check("clear_busy_cycles", busy_cnt, 48);
    check("clear_acks", acks, 0);
    nz = 0;
    for (int i = 0; i < 16; i++) if (mema[i] != 16'h0000) nz++;
    check("clear_nonzero_words", nz, 0);
    check("clear_word16_untouched", mema[16], 16'hBEEF);
    check("b_idle_no_clear", b_busy, 0);

    // ---- write 0xA to addr 0x05 over word 1 = 0x1234 ----
    prea(6'd1, 16'h1234);
    a_req(1'b1, 6'h05, 4'hA, 4'h0, ack_c, done_c, nack);
    check("wr_ack_cycle", ack_c, 1);
    check("wr_ack_count", nack, 1);
    check("wr_done_cycle", done_c, 6);
    check("wr_word1", mema[1], 16'h12A4);
    check("wr_rd_unchanged", a_rd, 4'h0);

    // ---- read addr 0x06 -> 0x2, held across a following write ----
    a_req(1'b0, 6'h06, 4'h0, 4'h2, ack_c, done_c, nack);
    check("rd_done_cycle", done_c, 3);
    a_req(1'b1, 6'h00, 4'h7, 4'h0, ack_c, done_c, nack);
    check("rd_held_after_wr", a_rd, 4'h2);
    check("wr_word0", mema[0], 16'h0007);

    // ---- m_ena held: back-to-back reads of addrs 0..7 ----
    prea(6'd0, 16'hC3A5);
    prea(6'd1, 16'h1E96);
    idx = 0; acks = 0; done = 0; last_ack = 0; prev_busy = a_busy;
    a_write = 1'b0; a_maddr = tbl[0].addr; sbq.push_back(tbl[0].exp); a_ena = 1'b1;
    for (int cyc = 1; cyc <= 80 && done < 8; cyc++) begin
      tick();
      if (a_ack) begin
        acks++;
        if (acks > 1) check("stream_ack_gap", cyc - last_ack, 3);
        last_ack = cyc;
        if (idx < 7) begin
          idx++;
          a_maddr = tbl[idx].addr;
          sbq.push_back(tbl[idx].exp);
        end else begin
          a_ena = 1'b0;
        end
      end
      if (prev_busy && !a_busy) begin
        done++;
        sb_pop("stream_rd_data", a_rd);
      end
      prev_busy = a_busy;
    end
    a_ena = 1'b0;
    check("stream_acks", acks, 8);
    check("stream_done", done, 8);
    check("stream_sb_empty", sbq.size(), 0);

    // ---- reset during the WR phase of a write to addr 0x09 (word 2) ----
    prea(6'd2, 16'h5555);
    a_ena = 1'b1; a_write = 1'b1; a_maddr = 6'h09; a_wd = 4'h3;
    tick();
    check("rstwr_ack", a_ack, 1);
    a_ena = 1'b0;
    tick();
    tick();
    check("rstwr_in_wr_phase", {a_we_n, a_dq_oe}, 2'b01);
    rst = 1'b1;
    tick();
    check("rstwr_strobes", {a_we_n, a_ce_n, a_oe_n}, 3'b111);
    check("rstwr_dq_oe", a_dq_oe, 0);
    check("rstwr_busy", a_busy, 1);
    tick();
    rst = 1'b0;
    done_c = -1;
    for (int k = 1; k <= 120; k++) begin
      tick();
      if (!a_busy) begin
        done_c = k;
        break;
      end
    end
    check("rstwr_clear_finished", (done_c > 0), 1);
    check("rstwr_word2_cleared", mema[2], 16'h0000);
    a_req(1'b0, 6'h09, 4'h0, 4'h0, ack_c, done_c, nack);

    // ---- B: full 16-bit address, write 0xF to 0xFFFF then read it ----
    preb(14'h3FFF, 16'h0123);
    b_ena = 1'b1; b_write = 1'b1; b_maddr = 16'hFFFF; b_wd = 4'hF;
    tick();
    check("b_wr_ack", b_ack, 1);
    check("b_sram_addr", b_saddr, 18'h03FFF);
    b_ena = 1'b0;
    done_c = -1;
    for (int k = 2; k <= 20; k++) begin
      tick();
      if (!b_busy) begin
        done_c = k;
        break;
      end
    end
    check("b_wr_done_cycle", done_c, 6);
    check("b_word_hi_nibble", memb[14'h3FFF][15:12], 4'hF);
    check("b_word", memb[14'h3FFF], 16'hF123);
    sbq.push_back(4'hF);
    b_ena = 1'b1; b_write = 1'b0;
    tick();
    check("b_rd_ack", b_ack, 1);
    b_ena = 1'b0;
    done_c = -1;
    for (int k = 2; k <= 20; k++) begin
      tick();
      if (!b_busy) begin
        done_c = k;
        break;
      end
    end
    check("b_rd_done_cycle", done_c, 3);
    sb_pop("b_rd_data", b_rd);

    check("strobe_rule_violations", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tape_sram_ctrl.md
# tape_sram_ctrl

Memory responder for the nibble-wide tape request interface (`m_ena`/`m_write`/`m_addr`/`wr_data`, `rd_data`/`m_busy`/`m_ack`) used by the Turing-machine cores. It replaces the single-cycle on-chip tape RAM with the board's external asynchronous 16-bit SRAM. Four 4-bit tape cells are packed per SRAM word, and nibble writes are done as read-modify-write. It sits between a Turing-machine core (the initiator) and the top-level SRAM pads.

## Interface
Parameters:
- `ABITS`, 16: nibble address width; SRAM word address is `m_addr[ABITS-1:2]`.
- `SRAM_AW`, 18: external SRAM address width; requires `ABITS-2 <= SRAM_AW`.
- `WAIT`, 2: cycles per SRAM read or write strobe phase; minimum 1.
- `CLEAR_ON_RESET`, 1: zero the tape region after reset.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, 50 MHz
- `rst`  in  1  synchronous active-high reset
- `m_ena`  in  1  request valid; held by initiator until `m_ack`
- `m_write`  in  1  1 = write, 0 = read
- `m_addr`  in  ABITS  nibble address
- `wr_data`  in  4  write nibble
- `rd_data`  out  4  read nibble
- `m_busy`  out  1  controller occupied
- `m_ack`  out  1  one-cycle request-accept pulse
- `sram_addr`  out  SRAM_AW  word address, zero-extended
- `sram_dq_i`  in  16  data from pad
- `sram_dq_o`  out  16  data to pad
- `sram_dq_oe`  out  1  pad drive enable
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n`  out  1 each  active-low strobes; `ub_n`/`lb_n` equal `ce_n`

## Operation
- All outputs are registered.
- Reset values, also held while `rst`=1:
  - `m_busy`=1, `m_ack`=0, `rd_data`=0
  - all strobes 1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_o`=0
- States: CLEAR, IDLE, RD, WR, WHOLD.
- **CLEAR** (`CLEAR_ON_RESET`=1):
  - For word = 0..2^(ABITS-2)-1: WAIT cycles with `we_n`=0 driving 0x0000, then 1 hold cycle with `we_n`=1 and data still driven.
  - `m_busy`=1 throughout; `m_ena` is ignored and never acked.
  - Afterwards go to IDLE.
  - With `CLEAR_ON_RESET`=0, go straight to IDLE.
- **IDLE**:
  - `m_busy`=0.
  - If `m_ena`=1, capture `m_write`, `m_addr`, `wr_data`, then enter RD.
  - `m_ack`=1 and `m_busy`=1 in the first RD cycle, so the initiator never sees ack without busy.
- **RD**:
  - `ce_n`=`oe_n`=0, `sram_addr`=captured word, for WAIT cycles.
  - `sram_dq_i` is sampled at the end of the last cycle.
  - Read request: `rd_data` <= nibble `sel`=`m_addr[1:0]`, i.e. bits [4*sel+3:4*sel], then go to IDLE.
  - Write request: merge the nibble into bits [4*sel+3:4*sel] of the sampled word, then go to WR.
- **WR**: `ce_n`=`we_n`=0, `oe_n`=1, `dq_oe`=1, merged word driven, for WAIT cycles; then WHOLD.
- **WHOLD**: `we_n`=1, `ce_n`=0, address and data still driven for 1 cycle; then IDLE.
- `rd_data` holds its value until the next accepted read completes; writes never change it.
- Inputs are sampled only in the IDLE accept cycle. Changes while busy are ignored.
- Reset mid-operation: on the next edge, strobes return inactive and `dq_oe`=0. A partial word write is permitted; CLEAR then rewrites it if enabled.
- Address arithmetic is unsigned. Every `m_addr` value maps in range; no wrap logic is required.

## Timing
- Cycle 0 is the IDLE cycle in which `m_ena`=1 is sampled.
- Cycle 1: `m_ack`=1, `m_busy`=1, read strobe begins.
- Read: `m_busy`=0 with `rd_data` valid at cycle WAIT+1.
- Write: `m_busy`=0 at cycle 2*WAIT+2.
- Minimum request period: WAIT+1 cycles for reads, 2*WAIT+2 for writes.
  - `m_ena` held continuously is re-accepted in the first `m_busy`=0 cycle.
- `oe_n` and `we_n` are never low in the same cycle.
- `dq_oe` is low throughout RD.
- CLEAR duration: 2^(ABITS-2) × (WAIT+1) cycles after `rst` falls.

## Structure
- Shared package `tape_mem_pkg`:
  - state enum
  - `NIB_PER_WORD`=4
  - nibble insert/extract functions, also used by the verification model
- Single module, no sub-module. The `sram_dq` tristate buffer (`dq_oe ? dq_o : 'z`) lives in the board top level.

## Test plan
All scenarios use WAIT=2 and a behavioural async-SRAM model.
- Reset, ABITS=6, CLEAR_ON_RESET=1 -> `m_busy`=1 for 48 cycles after `rst` falls; model words 0..15 all 0x0000; no `m_ack` even with `m_ena` held.
- Preload word 1 = 0x1234; write 0xA to addr 0x05 -> one `m_ack` at cycle 1; `m_busy` low at cycle 6; word 1 = 0x12A4; `rd_data` unchanged.
- Read addr 0x06 from word 0x12A4 -> `m_busy` low at cycle 3 with `rd_data`=0x2, held across a following write.
- `m_ena` held high with reads of addrs 0..7 -> `m_ack` every 3 cycles; 8 acks with correct nibbles; no request lost or duplicated.
- `rst` pulsed during the WR phase -> next cycle `we_n`=1, `ce_n`=1, `dq_oe`=0, `m_busy`=1; CLEAR restarts and the word reads back 0.
- ABITS=16: write 0xF to addr 0xFFFF, then read it -> `sram_addr`=0x03FFF; word bits [15:12]=0xF; `rd_data`=0xF.
